// File: rtl/hit_info_readout_stage.sv
// Hit-info RAM with a sequential read-out engine that streams entries 0..DEPTH-1 to the shading stage.
// Optional build macro HIT_INFO_CLEAR_ON_READ_EN: each read clears that entry's hit bit, so a pass consumes the data.
package hit_info_pkg;
  typedef struct packed {
    logic        hit;
    logic [31:0] t;
    logic [14:0] prim_id;
  } hit_info_t;
endpackage

module hit_info_readout_stage
  import hit_info_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hit_info_wr_en,
  input  logic [ADDR_WIDTH-1:0] update_hit_info_ndx,
  input  hit_info_t             hit_info_new,
  input  logic                  start,
  output logic                  busy,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [ADDR_WIDTH-1:0] out_ndx,
  output hit_info_t             out_hit_info,
  output logic [ADDR_WIDTH:0]   hit_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [ADDR_WIDTH:0]   LAST_CTR = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_NDX = ADDR_WIDTH'(DEPTH - 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] ndx;
    hit_info_t             info;
  } fifo_entry_t;

  hit_info_t             mem [DEPTH];
  hit_info_t             rd_q;
  logic [1:0]            state;
  logic [ADDR_WIDTH:0]   rd_ctr;
  logic                  rd_vld;
  logic [ADDR_WIDTH-1:0] rd_ndx_q;
  fifo_entry_t           fifo [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_cnt;

  logic                  rd_issue;
  logic                  pop;
  logic                  pop_fifo;
  logic                  push;
  logic                  fifo_nonempty;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // The read in flight (rd_q) counts toward the two-entry budget, so the FIFO never overflows.
  assign rd_addr       = rd_ctr[ADDR_WIDTH-1:0];
  assign fifo_nonempty = (fifo_cnt != 2'd0);
  assign rd_issue      = (state == READ) && ((fifo_cnt + {1'b0, rd_vld}) < 2'd2);
  assign out_vld       = fifo_nonempty || rd_vld;
  assign pop           = out_vld && out_rdy;
  assign pop_fifo      = pop && fifo_nonempty;
  // With an empty FIFO the fresh RAM word is the head and may be consumed directly.
  assign push          = rd_vld && !(pop && !fifo_nonempty);

  assign out_ndx      = fifo_nonempty ? fifo[rd_ptr].ndx  : rd_ndx_q;
  assign out_hit_info = fifo_nonempty ? fifo[rd_ptr].info : rd_q;
  assign busy         = (state != IDLE);

  // NOTE: the RAM array and its read register have no reset; clearing storage would block BRAM inference.
  always_ff @(posedge clk) begin
`ifdef HIT_INFO_CLEAR_ON_READ_EN
    // Placed before the trace write so a same-index write in this cycle overrides the clear.
    if (rd_vld) mem[rd_ndx_q].hit <= 1'b0;
`endif
    if (hit_info_wr_en) mem[update_hit_info_ndx] <= hit_info_new;
    // NOTE: non-blocking assignment makes a same-cycle write invisible to this read (read-first).
    if (rd_issue) rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_ctr    <= '0;
      rd_vld    <= 1'b0;
      rd_ndx_q  <= '0;
      hit_count <= '0;
      fifo[0]   <= '0;
      fifo[1]   <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_cnt  <= 2'd0;
    end else begin
      rd_vld <= rd_issue;
      if (rd_issue) rd_ndx_q <= rd_addr;

      if (push) begin
        fifo[wr_ptr] <= fifo_entry_t'{ndx: rd_ndx_q, info: rd_q};
        wr_ptr       <= ~wr_ptr;
      end
      if (pop_fifo) rd_ptr <= ~rd_ptr;
      case ({push, pop_fifo})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      if (state == IDLE && start) hit_count <= '0;
      else if (pop && out_hit_info.hit) hit_count <= hit_count + 1'b1;

      case (state)
        IDLE: if (start) begin
          state  <= READ;
          rd_ctr <= '0;
        end
        READ: if (rd_issue) begin
          rd_ctr <= rd_ctr + 1'b1;
          if (rd_ctr == LAST_CTR) state <= DRAIN;
        end
        DRAIN: if (pop && out_ndx == LAST_NDX) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
